// File: rtl/uart_rx_fifo_if.sv
`timescale 1ns/1ps
// uart_rx_fifo_if: CPU-side pop/status bundle between uart_rx_fifo and the gpio register block.
//   rd_en      pop strobe, one cycle per byte          (master -> slave)
//   clr_err    clears the sticky error flags           (master -> slave)
//   rd_data    head-of-FIFO byte, first-word fall-through
//   rx_valid   FIFO non-empty
//   rx_count   stored byte count, $clog2(FIFO_DEPTH)+1 bits
//   overrun    sticky: byte dropped on a full FIFO
//   frame_err  sticky: stop bit sampled low
//   parity_err sticky: even-parity mismatch (only with UART_RX_PARITY_EN)
interface uart_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd_en;
  logic             clr_err;
  logic [7:0]       rd_data;
  logic             rx_valid;
  logic [CNT_W-1:0] rx_count;
  logic             overrun;
  logic             frame_err;
`ifdef UART_RX_PARITY_EN
  logic             parity_err;

  modport master (
    output rd_en, clr_err,
    input  rd_data, rx_valid, rx_count, overrun, frame_err, parity_err
  );
  modport slave (
    input  rd_en, clr_err,
    output rd_data, rx_valid, rx_count, overrun, frame_err, parity_err
  );
`else
  modport master (
    output rd_en, clr_err,
    input  rd_data, rx_valid, rx_count, overrun, frame_err
  );
  modport slave (
    input  rd_en, clr_err,
    output rd_data, rx_valid, rx_count, overrun, frame_err
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo: 8N1 UART receiver (LSB first) feeding a first-word fall-through FIFO.
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   uart_txd_in  asynchronous serial line, idle high
//   bus          uart_rx_fifo_if.slave: rd_en/clr_err in; rd_data, rx_valid,
//                rx_count, overrun, frame_err (and parity_err) out
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit plus the sticky parity_err flag.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uart_txd_in,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned BCNT_W       = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W        = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic              parity_err_q, parity_err_d;
  logic              par_bad_q, par_bad_d;
`endif
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic rx_sync;
  logic bit_tick_c;
  logic push_c;
  logic full_c;
  logic empty_c;
  logic pop_c;
  logic wr_en_c;

  assign rx_sync = sync_q[1];

  // State, datapath and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_data_q    <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[0], uart_txd_in};
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  // FIFO storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  // Receiver FSM next-state plus FIFO pointer/flag update.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_c      = 1'b0;
    bit_tick_c  = (bcnt_q == '0);
    // Clear first so a coincident error event below wins.
    overrun_d   = overrun_q & ~bus.clr_err;
    frame_err_d = frame_err_q & ~bus.clr_err;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q & ~bus.clr_err;
    par_bad_d    = par_bad_q;
`endif

    if (!bit_tick_c) begin
      bcnt_d = bcnt_q - BCNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_sync) begin
          state_d = S_START;
          bcnt_d  = BCNT_W'(HALF_BIT - 1);
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (bit_tick_c) begin
          if (!rx_sync) begin
            state_d   = S_DATA;
            bcnt_d    = BCNT_W'(CLKS_PER_BIT - 1);
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (bit_tick_c) begin
          shift_d   = {rx_sync, shift_q[7:1]};
          bcnt_d    = BCNT_W'(CLKS_PER_BIT - 1);
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tick_c) begin
          bcnt_d  = BCNT_W'(CLKS_PER_BIT - 1);
          state_d = S_STOP;
          if (rx_sync != (^shift_q)) begin
            parity_err_d = 1'b1;
            par_bad_d    = 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (bit_tick_c) begin
          if (rx_sync) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            push_c  = ~par_bad_q;
`else
            push_c  = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end
      // Hold off through a break so it never yields 0x00 bytes.
      S_WAIT_IDLE: begin
        if (rx_sync) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_c = (wr_ptr_q == rd_ptr_q);
    pop_c   = bus.rd_en & ~empty_c;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en_c = push_c & (~full_c | pop_c);
    if (push_c && full_c && !pop_c) begin
      overrun_d = 1'b1;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    count_d  = wr_ptr_d - rd_ptr_d;
    valid_d  = (count_d != '0);
    // Bypass the byte being written when it becomes the new head.
    if (wr_en_c && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      rd_data_d = shift_q;
    end else begin
      rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.rx_count   = count_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo at 16 clk/bit, 4-entry FIFO.
module tb_uart_rx_fifo;
  localparam int unsigned CLK_HZ     = 1600;
  localparam int unsigned BAUD       = 100;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          CPB        = int'(CLK_HZ / BAUD);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_txd_in = 1'b1;

  uart_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_rx_fifo #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_txd_in(uart_txd_in),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int n);
    uart_txd_in = b;
    tick(n);
  endtask

  // One frame; pop_on_push raises rd_en exactly on the stop-bit sample cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl = 1'b1,
                            input int stop_bits = 1, input logic par_flip = 1'b0,
                            input bit pop_on_push = 1'b0);
    logic par;
    par = (^d) ^ par_flip;
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    send_bit(par, CPB);
`endif
    if (pop_on_push) begin
      uart_txd_in = 1'b1;
      tick(CPB - 6);
      check_eq("pop_on_push_count_before", 32'(bus.rx_count), 32'd4);
      if (sb_q.size() > 0) check_eq("pop_on_push_head", 32'(bus.rd_data), 32'(sb_q.pop_front()));
      bus.rd_en = 1'b1;
      tick(1);
      bus.rd_en = 1'b0;
      check_eq("pop_on_push_count_after", 32'(bus.rx_count), 32'd4);
      check_eq("pop_on_push_overrun", 32'(bus.overrun), 32'd0);
      tick(5);
    end else begin
      send_bit(stop_lvl, CPB * stop_bits);
    end
    uart_txd_in = 1'b1;
  endtask

  // Bounded wait for data, compare head against the scoreboard, then pop.
  task automatic read_one(input string tag);
    for (int i = 0; i < 20 * CPB && !bus.rx_valid; i++) tick();
    check_eq({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
    check_eq({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (bus.rx_valid && sb_q.size() != 0) begin
      check_eq({tag, "_data"}, 32'(bus.rd_data), 32'(sb_q.pop_front()));
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    rst_n       = 1'b0;
    tick(3);
    check_eq("rst_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("rst_count", 32'(bus.rx_count), 32'd0);
    check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
    check_eq("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check_eq("rst_rd_data", 32'(bus.rd_data), 32'h00);
`ifdef UART_RX_PARITY_EN
    check_eq("rst_parity_err", 32'(bus.parity_err), 32'd0);
`endif
    rst_n = 1'b1;
    tick(2);

    // Pop while empty is ignored.
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    tick();
    check_eq("empty_pop_count", 32'(bus.rx_count), 32'd0);
    check_eq("empty_pop_valid", 32'(bus.rx_valid), 32'd0);

    // Single frame.
    sb_q.push_back(8'hA5);
    send_frame(8'hA5);
    tick(2);
    check_eq("a5_valid", 32'(bus.rx_valid), 32'd1);
    check_eq("a5_count", 32'(bus.rx_count), 32'd1);
    read_one("a5");
    check_eq("a5_after_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("a5_after_count", 32'(bus.rx_count), 32'd0);

    // Five back-to-back frames into a 4-deep FIFO.
    for (int d = 1; d <= 5; d++) begin
      if (d <= 4) sb_q.push_back(8'(d));
      send_frame(8'(d));
    end
    tick(2);
    check_eq("ovr_count", 32'(bus.rx_count), 32'd4);
    check_eq("ovr_flag", 32'(bus.overrun), 32'd1);
    check_eq("ovr_frame_err", 32'(bus.frame_err), 32'd0);
    for (int i = 0; i < 4; i++) read_one("ovr_read");
    check_eq("ovr_drained", 32'(bus.rx_count), 32'd0);
    pulse_clr();
    check_eq("ovr_cleared", 32'(bus.overrun), 32'd0);

    // Short glitch on the line.
    uart_txd_in = 1'b0;
    tick(5);
    uart_txd_in = 1'b1;
    tick(3 * CPB);
    check_eq("glitch_count", 32'(bus.rx_count), 32'd0);
    check_eq("glitch_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("glitch_overrun", 32'(bus.overrun), 32'd0);
    check_eq("glitch_frame_err", 32'(bus.frame_err), 32'd0);

    // Stop bit held low, then a valid frame.
    send_frame(8'h3C, 1'b0, 3);
    tick(CPB);
    check_eq("ferr_flag", 32'(bus.frame_err), 32'd1);
    check_eq("ferr_count", 32'(bus.rx_count), 32'd0);
    pulse_clr();
    check_eq("ferr_cleared", 32'(bus.frame_err), 32'd0);
    sb_q.push_back(8'h7E);
    send_frame(8'h7E);
    tick(2);
    check_eq("7e_count", 32'(bus.rx_count), 32'd1);
    read_one("7e");

    // Full FIFO with a pop on the push cycle.
    for (int d = 8'h11; d <= 8'h14; d++) begin
      sb_q.push_back(8'(d));
      send_frame(8'(d));
    end
    tick(2);
    check_eq("full_count", 32'(bus.rx_count), 32'd4);
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) read_one("full_read");
    check_eq("full_drained", 32'(bus.rx_count), 32'd0);
    check_eq("full_overrun", 32'(bus.overrun), 32'd0);

    // Reset during bit 3 of 0xFF, then a clean 0x12.
    send_bit(1'b0, CPB);
    send_bit(1'b1, 3 * CPB + CPB / 2);
    rst_n = 1'b0;
    tick(2);
    check_eq("midrst_count", 32'(bus.rx_count), 32'd0);
    check_eq("midrst_valid", 32'(bus.rx_valid), 32'd0);
    rst_n = 1'b1;
    send_bit(1'b1, CPB / 2 + 5 * CPB);
    sb_q.push_back(8'h12);
    send_frame(8'h12);
    tick(2);
    check_eq("midrst_12_count", 32'(bus.rx_count), 32'd1);
    read_one("midrst_12");
    check_eq("midrst_drained", 32'(bus.rx_count), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Bad parity: flagged, byte discarded.
    send_frame(8'h12, 1'b1, 1, 1'b1);
    tick(2);
    check_eq("par_flag", 32'(bus.parity_err), 32'd1);
    check_eq("par_count", 32'(bus.rx_count), 32'd0);
    check_eq("par_frame_err", 32'(bus.frame_err), 32'd0);
    pulse_clr();
    check_eq("par_cleared", 32'(bus.parity_err), 32'd0);
    sb_q.push_back(8'h5A);
    send_frame(8'h5A);
    tick(2);
    read_one("par_good");
    check_eq("par_good_flag", 32'(bus.parity_err), 32'd0);
`endif

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
